// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, FSM state type and snapshot helper functions
package keypad_pkg;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KEY_W = 4;
  localparam int NKEYS = ROWS * COLS;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, EVAL} state_t;
  function automatic logic is_one(input logic [NKEYS-1:0] v);
    return v != '0 && (v & (v - NKEYS'(1))) == '0;
  endfunction
  function automatic logic ge_two(input logic [NKEYS-1:0] v);
    return (v & (v - NKEYS'(1))) != '0;
  endfunction
  function automatic logic [KEY_W-1:0] key_index(input logic [NKEYS-1:0] v);
    logic [KEY_W-1:0] c;
    c = '0;
    for (int i = 0; i < NKEYS; i++)
      if (v[i]) c = KEY_W'(i);
    return c;
  endfunction
endpackage

// File: rtl/keypad_matrix_debounce.sv
// keypad_matrix_debounce: accepts a snapshot once it repeats DEBOUNCE_SCANS times in a row
module keypad_matrix_debounce import keypad_pkg::*; #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] snap,
  input  logic             eval,
  output logic [NKEYS-1:0] stable,
  output logic             accept
);
  localparam int CW = DEBOUNCE_SCANS > 1 ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [CW-1:0] TOP = CW'(DEBOUNCE_SCANS - 1);
  logic [NKEYS-1:0] prev;
  logic [CW-1:0] cnt, cnt_nx;
  // saturating repeat count; accept fires combinationally in the eval cycle
  always_comb begin
    cnt_nx = snap != prev ? '0 : cnt == TOP ? cnt : cnt + 1'b1;
    accept = eval && cnt_nx == TOP;
  end
  // history and stable snapshot advance only on the eval strobe
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev <= '0;
      cnt <= '0;
      stable <= '0;
    end else if (eval) begin
      prev <= snap;
      cnt <= cnt_nx;
      if (accept) stable <= snap;
    end
endmodule

// File: rtl/keypad_scan_controller.sv
// keypad_scan_controller: paced column scan, debounced snapshots, single-key press events
module keypad_scan_controller import keypad_pkg::*; #(
  parameter int SETTLE_CYCLES = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_en,
  input  logic [ROWS-1:0]  keypad_row_in,
  output logic [COLS-1:0]  keypad_col_out,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_down,
  output logic             key_multi,
  output logic             overrun
);
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  state_t state, state_nx;
  logic [1:0] col;
  logic [SW-1:0] settle;
  logic [NKEYS-1:0] snap, stable;
  logic accept, press, settle_done;
  keypad_matrix_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_deb (
    .clk(clk),
    .rst(rst),
    .snap(snap),
    .eval(state == EVAL),
    .stable(stable),
    .accept(accept)
  );
  assign settle_done = settle == SW'(SETTLE_CYCLES - 1);
  // a press needs the previously accepted snapshot to be empty
  assign press = accept && stable == '0 && is_one(snap);
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state and column drive
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = scan_en ? DRIVE : IDLE;
      DRIVE:   state_nx = settle_done ? SAMPLE : DRIVE;
      SAMPLE:  state_nx = col == 2'd3 ? EVAL : DRIVE;
      EVAL:    state_nx = scan_en ? DRIVE : IDLE;
    endcase
    keypad_col_out = (state == DRIVE || state == SAMPLE) ? 4'b0001 << col : '0;
  end
  // settle timer, column index and snapshot capture; col wraps to 0 after the last column
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      settle <= '0;
      col <= '0;
      snap <= '0;
    end else begin
      settle <= state == DRIVE && !settle_done ? settle + 1'b1 : '0;
      if (state == SAMPLE) begin
        for (int r = 0; r < ROWS; r++) snap[{2'(r), col}] <= keypad_row_in[r];
        col <= col + 1'b1;
      end
    end
  // status flags and the single-entry event register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      key_down <= 1'b0;
      key_multi <= 1'b0;
      key_code <= '0;
      key_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (accept) begin
        key_down <= is_one(snap);
        key_multi <= ge_two(snap);
      end
      if (press && (!key_valid || key_ready)) begin
        key_code <= key_index(snap);
        key_valid <= 1'b1;
      end else if (press) overrun <= 1'b1;
      else if (key_ready) key_valid <= 1'b0;
    end
endmodule

// File: tb/tb_keypad_scan_controller.sv
// tb_keypad_scan_controller: directed scenarios with a keypad model and event scoreboard
module tb_keypad_scan_controller;
  logic clk = 1'b0, rst = 1'b1, scan_en = 1'b0, key_ready = 1'b1;
  logic [3:0] keypad_row_in, keypad_col_out, key_code;
  logic key_valid, key_down, key_multi, overrun;
  logic [15:0] pressed = '0;
  logic [3:0] q[$];
  int n_cmp = 0, n_err = 0;
  keypad_scan_controller dut (
    .clk(clk),
    .rst(rst),
    .scan_en(scan_en),
    .keypad_row_in(keypad_row_in),
    .keypad_col_out(keypad_col_out),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_down(key_down),
    .key_multi(key_multi),
    .overrun(overrun)
  );
  always #5 clk = ~clk;
  // keypad: row r reads closed when a pressed key sits in row r of a driven column
  always_comb begin
    keypad_row_in = '0;
    for (int r = 0; r < 4; r++) keypad_row_in[r] = |(pressed[r*4 +: 4] & keypad_col_out);
  end
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_col(input logic [3:0] v);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = keypad_col_out == v;
    end
    chk("wait_col", 16'(hit), 16'd1);
  endtask
  task automatic scans(input int n);
    for (int i = 0; i < n; i++) wait_col(4'd0);
  endtask
  // every delivered event must match the oldest expected code
  always @(negedge clk)
    if (!rst && key_valid && key_ready) begin
      chk("evt_expected", 16'(q.size() > 0), 16'd1);
      if (q.size() > 0) chk("evt_code", 16'(key_code), 16'(q.pop_front()));
    end
  initial begin
    logic [3:0] seen;
    @(negedge clk);
    chk("rst_col", 16'(keypad_col_out), 16'd0);
    chk("rst_valid", 16'(key_valid), 16'd0);
    chk("rst_flags", 16'({key_down, key_multi, overrun, key_code}), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    scan_en = 1'b1;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      chk("col_walk", 16'(keypad_col_out), k < 68 ? 16'(1 << (k / 17)) : k == 68 ? 16'd0 : 16'd1);
    end
    chk("idle_no_valid", 16'(key_valid), 16'd0);
    scans(1);
    pressed = 16'h0200;
    q.push_back(4'd9);
    scans(4);
    chk("pre_accept_valid", 16'(key_valid), 16'd0);
    @(negedge clk);
    chk("k9_valid", 16'(key_valid), 16'd1);
    chk("k9_code", 16'(key_code), 16'd9);
    chk("k9_down", 16'(key_down), 16'd1);
    @(negedge clk);
    chk("k9_cleared", 16'(key_valid), 16'd0);
    scans(2);
    pressed = '0;
    scans(4);
    @(negedge clk);
    chk("rel_down", 16'(key_down), 16'd0);
    for (int i = 0; i < 6; i++) begin
      pressed = i % 2 == 0 ? 16'h0200 : 16'h0000;
      scans(1);
    end
    pressed = 16'h0200;
    q.push_back(4'd9);
    scans(3);
    @(negedge clk);
    chk("bounce_no_evt", 16'(key_valid), 16'd0);
    scans(1);
    @(negedge clk);
    chk("bounce_valid", 16'(key_valid), 16'd1);
    chk("bounce_code", 16'(key_code), 16'd9);
    pressed = '0;
    scans(4);
    pressed = 16'h8001;
    scans(4);
    @(negedge clk);
    chk("multi", 16'(key_multi), 16'd1);
    chk("multi_down", 16'(key_down), 16'd0);
    chk("multi_no_evt", 16'(key_valid), 16'd0);
    pressed = '0;
    scans(4);
    @(negedge clk);
    chk("multi_rel", 16'(key_multi), 16'd0);
    pressed = 16'h8000;
    q.push_back(4'd15);
    scans(4);
    @(negedge clk);
    chk("k15_valid", 16'(key_valid), 16'd1);
    chk("k15_code", 16'(key_code), 16'd15);
    pressed = '0;
    scans(4);
    @(posedge clk);
    #1 key_ready = 1'b0;
    pressed = 16'h0008;
    q.push_back(4'd3);
    scans(4);
    @(negedge clk);
    chk("k3_valid", 16'(key_valid), 16'd1);
    chk("k3_code", 16'(key_code), 16'd3);
    pressed = '0;
    scans(4);
    pressed = 16'h0080;
    scans(4);
    chk("pre_ovr", 16'(overrun), 16'd0);
    @(negedge clk);
    chk("ovr_pulse", 16'(overrun), 16'd1);
    chk("ovr_code", 16'(key_code), 16'd3);
    chk("ovr_valid", 16'(key_valid), 16'd1);
    @(negedge clk);
    chk("ovr_end", 16'(overrun), 16'd0);
    @(posedge clk);
    #1 key_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("k3_cleared", 16'(key_valid), 16'd0);
    wait_col(4'd2);
    scan_en = 1'b0;
    wait_col(4'd4);
    wait_col(4'd8);
    wait_col(4'd0);
    seen = '0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      seen |= keypad_col_out;
    end
    chk("idle_stays_off", 16'(seen), 16'd0);
    chk("idle_key_down", 16'(key_down), 16'd1);
    scan_en = 1'b1;
    wait_col(4'd2);
    rst = 1'b1;
    #1;
    chk("arst_col", 16'(keypad_col_out), 16'd0);
    chk("arst_code", 16'(key_code), 16'd0);
    chk("arst_flags", 16'({key_valid, key_down, key_multi, overrun}), 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    scan_en = 1'b0;
    @(negedge clk);
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/keypad_scan_controller.md
Name: keypad_scan_controller

Overview:
Sequences scanning of a 4x4 keypad matrix. It drives one column at a time, waits a settle time, samples the rows, and assembles a 16-bit snapshot per scan. Snapshots are debounced. Each debounced single-key press is delivered as a 4-bit key code over a valid/ready handshake. It sits between the raw keypad pins and downstream key consumers, replacing free-running polling with a paced, debounced scheduler.

Parameters:
SETTLE_CYCLES, 16, cycles each column is driven before rows are sampled (>=1)
DEBOUNCE_SCANS, 4, consecutive identical snapshots required before a snapshot is accepted as stable (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
scan_en  input  1  1 = scanning enabled
keypad_row_in  input  4  row sense; bit r=1 means a key in row r of the driven column is closed
keypad_col_out  output  4  one-hot active-high column drive; 0 when not scanning
key_code  output  4  code of the pressed key = 4*row + col
key_valid  output  1  key_code holds an undelivered event
key_ready  input  1  consumer accepts the event when key_valid && key_ready
key_down  output  1  current stable snapshot has exactly one key closed
key_multi  output  1  current stable snapshot has two or more keys closed
overrun  output  1  one-cycle pulse: a press event was dropped

Behaviour:
- Reset (async, rst=1): state IDLE; keypad_col_out=0, key_code=0, key_valid=0, key_down=0, key_multi=0, overrun=0. Snapshot, previous snapshot, stable snapshot and debounce count all 0; column index 0.
- FSM states: IDLE, DRIVE, SAMPLE, EVAL.
- IDLE: keypad_col_out=0. Goes to DRIVE with col=0 when scan_en=1.
- DRIVE: keypad_col_out=1<<col. Settle counter runs for SETTLE_CYCLES cycles, then goes to SAMPLE.
- SAMPLE (1 cycle): column still driven. keypad_row_in[r] is latched into snapshot bit 4*r+col. If col==3, go to EVAL; else col+1 and DRIVE.
- EVAL (1 cycle): keypad_col_out=0. Compare snapshot to previous snapshot:
  - equal: debounce count increments, saturating at DEBOUNCE_SCANS-1;
  - differ: debounce count = 0.
  - previous snapshot <= snapshot.
- Acceptance: in EVAL, when the count is DEBOUNCE_SCANS-1 after the update, the snapshot becomes the stable snapshot. With DEBOUNCE_SCANS=1, every snapshot is accepted.
- After EVAL: go to DRIVE col 0 if scan_en=1, else IDLE. Deasserting scan_en mid-scan finishes the current scan, including EVAL.
- Scan period = 4*(SETTLE_CYCLES+1)+1 cycles (69 at defaults).
- key_down / key_multi are registered and update in the cycle after a stable snapshot is accepted.
- Press event:
  - Fires when the stable snapshot changes from all-zero to exactly one bit set.
  - Code = index of that bit.
  - Moving from one key to another without an all-zero stable snapshot in between generates no event.
  - Multi-key stable snapshots generate no event.
  - All-zero re-arms event generation.
- Output register:
  - On an event with key_valid=0, or with key_valid=1 && key_ready=1 in the same cycle: key_code <= code and key_valid=1 from the next cycle.
  - On an event with key_valid=1 && key_ready=0: event dropped, key_code unchanged, overrun=1 for one cycle.
  - A handshake with no event clears key_valid next cycle.
  - key_code holds its last value while key_valid=0.
- keypad_row_in is sampled only in SAMPLE. The block does not synchronize it; the integrator adds a 2-flop synchronizer upstream.
- Reset asserted mid-scan or while key_valid=1 returns everything to reset values immediately. The pending event is lost, and no overrun pulse is generated.

Decomposition:
- keypad_pkg: ROWS=4, COLS=4, KEY_W=4, state enum (IDLE, DRIVE, SAMPLE, EVAL), popcount-is-one and popcount-ge-two functions, one-hot index-to-code function.
- One sub-module, keypad_matrix_debounce: holds previous snapshot, debounce count, and stable snapshot. Its input is a 16-bit snapshot plus an eval strobe. Its outputs are the stable snapshot and an accept pulse.
- The controller holds the FSM, column/settle counters, event detection and the output handshake register.

Test Plan:
1. Reset then scan_en=1, no keys: keypad_col_out walks 1,2,4,8, each held 17 cycles, with 1 cycle of 0 between scans. key_valid never rises; period 69 cycles.
2. Row 2 asserted while col 1 is driven, steady, key_ready=1: key_valid rises 1 cycle after the EVAL of the 4th scan with key_code=9, key_down=1. Handshake clears key_valid. Holding the key produces no second event.
3. Row 2/col 1 toggling every other scan for 6 scans, then steady: no event until 4 consecutive identical scans, then a single key_code=9.
4. Keys 0 and 15 stable together: key_multi=1, key_down=0, no event. Releasing all, then pressing key 15 alone, gives key_code=15.
5. key_ready=0 while event key_code=3 is pending; key 3 is released, then key 7 is pressed and becomes stable: overrun pulses 1 cycle, key_code stays 3. After key_ready=1, key_valid clears.
6. scan_en dropped while col 1 is driven: finishes col 2, col 3 and EVAL, then keypad_col_out=0 in IDLE. rst pulsed mid-DRIVE: outputs return to reset values within the same cycle (async).
